// File: rtl/video_scanmult.sv
// Line-buffer scan multiplier: captures one scanline into a ping-pong RAM at the
// input pixel rate and replays the last finished line MULT times at the output rate.
module video_scanmult #(
    parameter int PIX_W    = 6,
    parameter int LINE_LEN = 896,
    parameter int ADDR_W   = 10,
    parameter int MULT     = 2,
    parameter int WR_DIV   = 2,
    parameter int RD_DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             scanin_start,
    input  logic             scanout_start,
    input  logic [PIX_W-1:0] pix_in,
    output logic [PIX_W-1:0] pix_out,
    output logic             out_active,
    output logic [1:0]       rep_idx,
    output logic             rep_err
);

    localparam int              DEPTH    = 2 * (2 ** ADDR_W);
    localparam logic [ADDR_W:0] LINE_END = (ADDR_W + 1)'(LINE_LEN);
    localparam logic [2:0]      WR_LAST  = 3'(WR_DIV - 1);
    localparam logic [2:0]      RD_LAST  = 3'(RD_DIV - 1);
    localparam logic [1:0]      REP_LAST = 2'(MULT - 1);

    logic [PIX_W-1:0] mem [DEPTH];

    logic              wr_bank_reg;
    logic [ADDR_W:0]   wr_addr_reg;
    logic [2:0]        wr_div_reg;
    logic              rd_bank_reg;
    logic [ADDR_W:0]   rd_addr_reg;
    logic [2:0]        rd_div_reg;
    logic              rd_ok_reg;
    logic [1:0]        bank_valid_reg;
    logic              new_line_reg;
    logic [PIX_W-1:0]  rd_data_reg;
    logic              rd_valid_reg;
    logic              rd_live_reg;

    logic wr_busy;
    logic wr_strobe;
    logic rd_busy;
    logic rd_sel_bank;

    assign wr_busy   = (wr_addr_reg < LINE_END);
    assign wr_strobe = wr_busy && (wr_div_reg == 3'd0) && !scanin_start;
    assign rd_busy   = (rd_addr_reg < LINE_END);
    // A start on the same clock finishes the bank being written, so read that one.
    assign rd_sel_bank = scanin_start ? wr_bank_reg : ~wr_bank_reg;

    always_ff @(posedge clk) begin
        if (wr_strobe) begin
            mem[{wr_bank_reg, wr_addr_reg[ADDR_W-1:0]}] <= pix_in;
        end
        rd_data_reg <= mem[{rd_bank_reg, rd_addr_reg[ADDR_W-1:0]}];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank_reg <= 1'b0;
            wr_addr_reg <= LINE_END;
            wr_div_reg  <= 3'd0;
        end else if (scanin_start) begin
            wr_bank_reg <= ~wr_bank_reg;
            wr_addr_reg <= '0;
            wr_div_reg  <= 3'd0;
        end else if (wr_busy) begin
            if (wr_div_reg == 3'd0) begin
                wr_addr_reg <= wr_addr_reg + 1'b1;
            end
            wr_div_reg <= (wr_div_reg == WR_LAST) ? 3'd0 : wr_div_reg + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_bank_reg <= 1'b0;
            rd_addr_reg <= LINE_END;
            rd_div_reg  <= 3'd0;
            rd_ok_reg   <= 1'b0;
        end else if (scanout_start) begin
            rd_bank_reg <= rd_sel_bank;
            rd_addr_reg <= '0;
            rd_div_reg  <= 3'd0;
            rd_ok_reg   <= bank_valid_reg[rd_sel_bank];
        end else if (rd_busy) begin
            if (rd_div_reg == RD_LAST) begin
                rd_div_reg  <= 3'd0;
                rd_addr_reg <= rd_addr_reg + 1'b1;
            end else begin
                rd_div_reg <= rd_div_reg + 3'd1;
            end
        end
    end

    // Banks not captured since reset replay as blank rather than stale RAM contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_valid_reg <= 2'b00;
            new_line_reg   <= 1'b0;
            rep_idx        <= 2'd0;
            rep_err        <= 1'b0;
        end else begin
            rep_err <= 1'b0;
            if (scanin_start) begin
                bank_valid_reg[~wr_bank_reg] <= 1'b1;
            end
            if (scanout_start) begin
                if (new_line_reg || scanin_start) begin
                    rep_idx      <= 2'd0;
                    new_line_reg <= 1'b0;
                end else if (rep_idx < REP_LAST) begin
                    rep_idx <= rep_idx + 2'd1;
                end else begin
                    rep_err <= en;
                end
            end else if (scanin_start) begin
                new_line_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_reg <= 1'b0;
            rd_live_reg  <= 1'b0;
            pix_out      <= '0;
            out_active   <= 1'b0;
        end else begin
            rd_valid_reg <= rd_busy;
            rd_live_reg  <= rd_busy && rd_ok_reg;
            if (!en) begin
                pix_out <= pix_in;
            end else begin
                pix_out <= rd_live_reg ? rd_data_reg : '0;
            end
            out_active <= en && rd_valid_reg;
        end
    end

endmodule

// File: tb/tb_video_scanmult.sv
// Directed bench for video_scanmult: bypass vector table plus hand-written
// capture/replay sequences with hand-computed pixel expectations.
module tb_video_scanmult;

    localparam int PIX_W    = 6;
    localparam int LINE_LEN = 8;
    localparam int ADDR_W   = 3;
    localparam int MULT     = 2;
    localparam int WR_DIV   = 2;
    localparam int RD_DIV   = 1;

    if (MULT < 1 || MULT > 4 || LINE_LEN < 1 || LINE_LEN > 2 ** ADDR_W ||
        WR_DIV < 1 || WR_DIV > 8 || RD_DIV < 1 || RD_DIV > 8) begin : g_bad_params
        initial $fatal(1, "illegal parameter set for video_scanmult");
    end

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             scanin_start;
    logic             scanout_start;
    logic [PIX_W-1:0] pix_in;
    logic [PIX_W-1:0] pix_out;
    logic             out_active;
    logic [1:0]       rep_idx;
    logic             rep_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] pix_in;
        logic [5:0] exp_before;
        logic [5:0] exp_after;
        logic       exp_active;
    } byp_vec_t;

    byp_vec_t byp_tab [8];

    video_scanmult #(
        .PIX_W   (PIX_W),
        .LINE_LEN(LINE_LEN),
        .ADDR_W  (ADDR_W),
        .MULT    (MULT),
        .WR_DIV  (WR_DIV),
        .RD_DIV  (RD_DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .scanin_start (scanin_start),
        .scanout_start(scanout_start),
        .pix_in       (pix_in),
        .pix_out      (pix_out),
        .out_active   (out_active),
        .rep_idx      (rep_idx),
        .rep_err      (rep_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Feed n pixels off, off+1, ... each held for one write-strobe period.
    task automatic capture(input int off, input int n);
        scanin_start = 1'b1;
        tick();
        scanin_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            pix_in = PIX_W'(off + i);
            repeat (WR_DIV) tick();
        end
        pix_in = '0;
        $display("capture start=%0d count=%0d", off, n);
    endtask

    // Issue scanout_start and check the whole replay window against off + step*i.
    task automatic replay(input string name, input bit with_scanin, input int off,
                          input int step, input int exp_rep, input bit exp_err);
        scanout_start = 1'b1;
        scanin_start  = with_scanin;
        tick();
        scanout_start = 1'b0;
        scanin_start  = 1'b0;
        check({name, ".rep_idx"}, int'(rep_idx), exp_rep);
        check({name, ".rep_err"}, int'(rep_err), int'(exp_err));
        tick();
        check({name, ".lead_active"}, int'(out_active), 0);
        check({name, ".lead_pix"}, int'(pix_out), 0);
        check({name, ".err_pulse_end"}, int'(rep_err), 0);
        for (int i = 0; i < LINE_LEN; i++) begin
            tick();
            check({name, ".active"}, int'(out_active), 1);
            check({name, ".pix"}, int'(pix_out), (off + step * i) % 64);
        end
        tick();
        check({name, ".tail_active"}, int'(out_active), 0);
        check({name, ".tail_pix"}, int'(pix_out), 0);
        $display("replay %s rep_idx=%0d rep_err=%0d", name, exp_rep, exp_err);
    endtask

    initial begin
        byp_tab[0] = '{6'h2A, 6'h00, 6'h2A, 1'b0};
        byp_tab[1] = '{6'h15, 6'h2A, 6'h15, 1'b0};
        byp_tab[2] = '{6'h3F, 6'h15, 6'h3F, 1'b0};
        byp_tab[3] = '{6'h01, 6'h3F, 6'h01, 1'b0};
        byp_tab[4] = '{6'h20, 6'h01, 6'h20, 1'b0};
        byp_tab[5] = '{6'h00, 6'h20, 6'h00, 1'b0};
        byp_tab[6] = '{6'h07, 6'h00, 6'h07, 1'b0};
        byp_tab[7] = '{6'h38, 6'h07, 6'h38, 1'b0};

        rst_n = 1'b0; en = 1'b1; scanin_start = 1'b0; scanout_start = 1'b0; pix_in = '0;
        tick();
        tick();
        check("reset.pix_out", int'(pix_out), 0);
        check("reset.out_active", int'(out_active), 0);
        check("reset.rep_idx", int'(rep_idx), 0);
        check("reset.rep_err", int'(rep_err), 0);
        rst_n = 1'b1;
        tick();
        check("idle.out_active", int'(out_active), 0);

        // Test 1: capture 1..8, close the line, replay it
        capture(1, LINE_LEN);
        repeat (3) tick();
        scanin_start = 1'b1;
        tick();
        scanin_start = 1'b0;
        replay("t1", 1'b0, 1, 1, 0, 1'b0);

        // Test 2: two more replays of the same line
        replay("t2a", 1'b0, 1, 1, 1, 1'b0);
        replay("t2b", 1'b0, 1, 1, 1, 1'b1);

        // Test 3: simultaneous starts read the bank that just finished
        capture(1, LINE_LEN);
        capture(11, LINE_LEN);
        replay("t3", 1'b1, 11, 1, 0, 1'b0);

        // Test 4: overlong line is truncated, no wrap
        capture(31, 12);
        replay("t4", 1'b1, 31, 1, 0, 1'b0);

        // Test 5: reset in the middle of a replay
        scanout_start = 1'b1;
        tick();
        scanout_start = 1'b0;
        check("t5.rep_idx", int'(rep_idx), 1);
        tick();
        tick();
        check("t5.mid_active", int'(out_active), 1);
        check("t5.mid_pix0", int'(pix_out), 31);
        tick();
        check("t5.mid_pix1", int'(pix_out), 32);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5.rst_pix", int'(pix_out), 0);
        check("t5.rst_active", int'(out_active), 0);
        check("t5.rst_rep_idx", int'(rep_idx), 0);
        check("t5.rst_rep_err", int'(rep_err), 0);
        $display("reset mid-replay");
        replay("t5_blank", 1'b0, 0, 0, 1, 1'b0);

        // Test 6a: bypass vector table
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("byp.before", int'(pix_out), int'(byp_tab[i].exp_before));
            pix_in = byp_tab[i].pix_in;
            tick();
            check("byp.after", int'(pix_out), int'(byp_tab[i].exp_after));
            check("byp.active", int'(out_active), int'(byp_tab[i].exp_active));
            $display("bypass vec %0d pix_in=%0d pix_out=%0d", i, byp_tab[i].pix_in, pix_out);
        end

        // Test 6b: ramp in bypass while the write side captures, then replay
        scanin_start = 1'b1;
        pix_in = '0;
        tick();
        scanin_start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            pix_in = PIX_W'(k);
            tick();
            check("t6.ramp_pix", int'(pix_out), k);
            check("t6.ramp_active", int'(out_active), 0);
        end
        $display("bypass ramp 0..63 done");
        en = 1'b1;
        replay("t6", 1'b1, 0, 2, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
